// File: rtl/nabp_angle_pkg.sv
// rtl/nabp_angle_pkg.sv - shared projection-angle constants, feeder states and sweep-length helper
package nabp_angle_pkg;

   localparam int kAngleLength = 8;
   localparam int kAngle45     = 45;
   localparam int kAngle135    = 135;
   localparam int kAngle180    = 180;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ACK  = 2'd2,
      S_FIN  = 2'd3
   } feeder_state_t;

   // Angles issued by one sweep: ceil((a_end - a_start) / a_step).
   function automatic int sweep_count(input int a_start, input int a_step, input int a_end);
      return (a_end - a_start + a_step - 1) / a_step;
   endfunction

endpackage

// File: rtl/nabp_angle_feeder.sv
// rtl/nabp_angle_feeder.sv - answers swap-control angle requests with the next angle of a programmed sweep
// Optional saturating stall counter output: define NABP_ANGLE_FEEDER_STALL_CNT_EN.
module nabp_angle_feeder
   import nabp_angle_pkg::*;
#(
   parameter int ANGLE_WIDTH = kAngleLength,
   parameter int ANGLE_START = 0,
   parameter int ANGLE_STEP  = 1,
   parameter int ANGLE_END   = kAngle180
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic                   hs_next_angle,
   output logic [ANGLE_WIDTH-1:0] hs_angle,
   output logic                   hs_next_angle_ack,
   output logic                   busy,
   output logic                   done,
   output logic [ANGLE_WIDTH:0]   angle_cnt
`ifdef NABP_ANGLE_FEEDER_STALL_CNT_EN
   ,
   output logic [31:0]            stall_cycles
`endif
);

   localparam logic [ANGLE_WIDTH-1:0] L_START = ANGLE_WIDTH'(ANGLE_START);
   localparam logic [ANGLE_WIDTH:0]   L_STEP  = (ANGLE_WIDTH+1)'(ANGLE_STEP);
   localparam logic [ANGLE_WIDTH:0]   L_END   = (ANGLE_WIDTH+1)'(ANGLE_END);
   localparam logic [ANGLE_WIDTH:0]   L_ONE   = (ANGLE_WIDTH+1)'(1);

   feeder_state_t          r_state;
   logic [ANGLE_WIDTH-1:0] r_angle;
   logic                   r_ack;
   logic                   r_busy;
   logic                   r_done;
   logic [ANGLE_WIDTH:0]   r_cnt;

   // One extra bit so the end-of-sweep compare cannot wrap.
   logic [ANGLE_WIDTH:0]   w_next_angle;
   logic                   w_more;

   assign w_next_angle = {1'b0, r_angle} + L_STEP;
   assign w_more       = (w_next_angle < L_END);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_angle <= L_START;
         r_ack   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_ack <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_cnt   <= '0;
                  r_done  <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (hs_next_angle) begin
                  if (r_cnt == '0) begin
                     r_ack   <= 1'b1;
                     r_angle <= L_START;
                     r_cnt   <= L_ONE;
                     r_state <= S_ACK;
                  end else if (w_more) begin
                     r_ack   <= 1'b1;
                     r_angle <= w_next_angle[ANGLE_WIDTH-1:0];
                     r_cnt   <= r_cnt + L_ONE;
                     r_state <= S_ACK;
                  end else begin
                     r_state <= S_FIN;
                  end
               end
            end
            // Swap control drops its request on the ack, so the request is not looked at here.
            S_ACK: r_state <= S_WAIT;
            S_FIN: begin
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign hs_angle          = r_angle;
   assign hs_next_angle_ack = r_ack;
   assign busy              = r_busy;
   assign done              = r_done;
   assign angle_cnt         = r_cnt;

`ifdef NABP_ANGLE_FEEDER_STALL_CNT_EN
   logic [31:0] r_stall;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_stall <= '0;
      end else if (r_state == S_IDLE && start) begin
         r_stall <= '0;
      end else if (r_state == S_WAIT && !hs_next_angle && r_busy && r_stall != 32'hFFFF_FFFF) begin
         r_stall <= r_stall + 32'd1;
      end
   end

   assign stall_cycles = r_stall;
`endif

endmodule

// File: tb/tb_nabp_angle_feeder.sv
// tb/tb_nabp_angle_feeder.sv - directed bench for nabp_angle_feeder (default and 10/45/180 sweeps)
module tb_nabp_angle_feeder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start_a = 1'b0, req_a = 1'b0;
   logic       start_b = 1'b0, req_b = 1'b0;
   logic [7:0] angle_a, angle_b;
   logic       ack_a, ack_b, busy_a, busy_b, done_a, done_b;
   logic [8:0] cnt_a, cnt_b;
`ifdef NABP_ANGLE_FEEDER_STALL_CNT_EN
   logic [31:0] stall_a, stall_b;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   nabp_angle_feeder dut_a (
      .clk(clk), .reset_n(rst_n), .start(start_a), .hs_next_angle(req_a),
      .hs_angle(angle_a), .hs_next_angle_ack(ack_a), .busy(busy_a), .done(done_a),
      .angle_cnt(cnt_a)
`ifdef NABP_ANGLE_FEEDER_STALL_CNT_EN
      , .stall_cycles(stall_a)
`endif
   );

   nabp_angle_feeder #(.ANGLE_START(10), .ANGLE_STEP(45), .ANGLE_END(180)) dut_b (
      .clk(clk), .reset_n(rst_n), .start(start_b), .hs_next_angle(req_b),
      .hs_angle(angle_b), .hs_next_angle_ack(ack_b), .busy(busy_b), .done(done_b),
      .angle_cnt(cnt_b)
`ifdef NABP_ANGLE_FEEDER_STALL_CNT_EN
      , .stall_cycles(stall_b)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req_cycle(input bit sel);
      if (sel) req_b = 1'b1;
      else     req_a = 1'b1;
      tick();
      req_a = 1'b0;
      req_b = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      tick();
      tick();
      chk("rst_angle_a", angle_a, 0);
      chk("rst_angle_b", angle_b, 10);
      chk("rst_ack", ack_a, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_done", done_a, 0);
      chk("rst_cnt", cnt_a, 0);
      rst_n = 1'b1;
      tick();

      // requests while idle
      for (int i = 0; i < 3; i++) begin
         req_cycle(0);
         chk("idle_ack", ack_a, 0);
      end

      // full default sweep 0..179
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      chk("a_busy", busy_a, 1);
      chk("a_cnt0", cnt_a, 0);
      for (int i = 0; i < 180; i++) begin
         req_cycle(0);
         chk("a_ack", ack_a, 1);
         chk("a_angle", angle_a, i);
         chk("a_cnt", cnt_a, i + 1);
         tick();
         chk("a_ack_low", ack_a, 0);
      end
      req_cycle(0);
      chk("a_last_noack", ack_a, 0);
      chk("a_done_early", done_a, 0);
      tick();
      chk("a_done", done_a, 1);
      chk("a_busy_end", busy_a, 0);
      chk("a_cnt_end", cnt_a, 180);
      for (int i = 0; i < 3; i++) begin
         req_cycle(0);
         chk("after_done_ack", ack_a, 0);
         chk("after_done_hold", done_a, 1);
      end

      // 10/45/180 sweep with 3-cycle gaps; start on the FIN cycle is ignored
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      for (int i = 0; i < 4; i++) begin
         req_cycle(1);
         chk("b_ack", ack_b, 1);
         chk("b_angle", angle_b, 10 + 45 * i);
         chk("b_cnt", cnt_b, i + 1);
         tick();
         repeat (3) tick();
      end
      req_cycle(1);
      chk("b_last_noack", ack_b, 0);
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      chk("b_done", done_b, 1);
      chk("b_busy_end", busy_b, 0);
      chk("b_cnt_end", cnt_b, 4);
`ifdef NABP_ANGLE_FEEDER_STALL_CNT_EN
      chk("b_stall", stall_b, 12);
`endif
      tick();
      chk("b_fin_start_ignored", busy_b, 0);
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      chk("b_restart_busy", busy_b, 1);
      chk("b_restart_done", done_b, 0);
`ifdef NABP_ANGLE_FEEDER_STALL_CNT_EN
      chk("b_stall_clr", stall_b, 0);
`endif

      // request held high: acks on alternate cycles only
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      req_a = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         chk("held_ack", ack_a, k % 2);
         chk("held_angle", angle_a, (k - 1) / 2);
      end
      req_a = 1'b0;

      // mid-sweep start has no effect
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      chk("mid_start_busy", busy_a, 1);
      chk("mid_start_cnt", cnt_a, 10);
      for (int a = 10; a <= 37; a++) begin
         req_cycle(0);
         chk("mid_ack", ack_a, 1);
         chk("mid_angle", angle_a, a);
         if (a != 37) tick();
      end

      // asynchronous reset while in ACK at angle 37
      #2 rst_n = 1'b0;
      #1;
      chk("arst_ack", ack_a, 0);
      chk("arst_angle", angle_a, 0);
      chk("arst_busy", busy_a, 0);
      chk("arst_cnt", cnt_a, 0);
      chk("arst_done", done_a, 0);
      #1 rst_n = 1'b1;
      tick();
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      req_cycle(0);
      chk("restart_ack", ack_a, 1);
      chk("restart_angle", angle_a, 0);
      chk("restart_cnt", cnt_a, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
